sram_access_ctrl: RTL
=====================

SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 10: number of SRAM words accessed (addresses 0..DEPTH-1).
REQ-002 SHALL have parameter AW, default 4: SRAM address width.
REQ-003 SHALL have parameter DW, default 16: SRAM data width.
REQ-004 SHALL have port iClk12M  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port iRsn  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port iWrReq  input  1  host single-word write request.
REQ-007 SHALL have port iWrAddr  input  AW  host write address.
REQ-008 SHALL have port iWrData  input  DW  host write data.
REQ-009 SHALL have port iRdStart  input  1  host request to sweep-read addresses 0..DEPTH-1.
REQ-010 SHALL have port oBusy  output  1  controller not in IDLE.
REQ-011 SHALL have port oWrAck  output  1  one-cycle write completion pulse.
REQ-012 SHALL have port oWrErr  output  1  one-cycle pulse, write address out of range, no SRAM write.
REQ-013 SHALL have port oRdValid  output  1  oRdData/oRdIdx valid this cycle.
REQ-014 SHALL have port oRdData  output  DW  read word.
REQ-015 SHALL have port oRdIdx  output  AW  address of oRdData.
REQ-016 SHALL have port oDone  output  1  one-cycle pulse, sweep complete.
REQ-017 SHALL have port oCsnRam  output  1  SRAM chip select, active-low.
REQ-018 SHALL have port oWrnRam  output  1  SRAM write enable, active-low (1 = read).
REQ-019 SHALL have port oAddrRam  output  AW  SRAM address.
REQ-020 SHALL have port oWtDtRam  output  DW  SRAM write data.
REQ-021 SHALL have port iRdDtRam  input  DW  SRAM registered read data (valid the cycle after a read access cycle).

Function
REQ-022 SHALL implement states IDLE, WRITE, READ, DRAIN; all outputs registered.
REQ-023 SHALL accept requests only in IDLE; iWrReq/iRdStart while oBusy=1 ignored, not queued.
REQ-024 SHALL give iWrReq priority when iWrReq and iRdStart sampled together in IDLE; iRdStart dropped.
REQ-025 SHALL, on iWrReq accepted at edge E0, enter WRITE for cycle 1: oCsnRam=0, oWrnRam=0, oAddrRam=iWrAddr, oWtDtRam=iWrData (captured at E0), oWrAck=1; return to IDLE at next edge.
REQ-026 SHALL, when iWrAddr >= DEPTH, keep oCsnRam=1 in cycle 1 and pulse oWrErr=1 together with oWrAck=1.
REQ-027 SHALL, on iRdStart accepted at E0, drive oCsnRam=0, oWrnRam=1, oAddrRam=k in cycle k+1 for k=0..DEPTH-1 (state READ), then oCsnRam=1 (state DRAIN).
REQ-028 SHALL capture iRdDtRam in cycle k+2 and present oRdValid=1, oRdData=word k, oRdIdx=k in cycle k+3.
REQ-029 SHALL assert oDone=1 in the same cycle as the oRdValid for k=DEPTH-1 (cycle DEPTH+2) and return to IDLE at the following edge.
REQ-030 SHALL hold oBusy=1 in cycles 1..DEPTH+2 of a sweep and cycle 1 of a write; 0 otherwise.
REQ-031 SHALL keep oCsnRam=1, oWrnRam=1 in IDLE and DRAIN; oAddrRam/oWtDtRam hold last value.
REQ-032 SHALL use a sweep counter of AW bits that terminates at DEPTH-1, never wrapping to 0 within a sweep.
REQ-033 SHALL leave oRdData holding the last word when oRdValid=0.

Reset
REQ-034 SHALL, on iRsn=0 (asynchronously, including mid-write or mid-sweep), force state IDLE, counter 0, oCsnRam=1, oWrnRam=1, oAddrRam=0, oWtDtRam=0, oRdData=0, oRdIdx=0, oBusy=0, oWrAck=0, oWrErr=0, oRdValid=0, oDone=0.
REQ-035 SHALL abandon an interrupted sweep; no oDone and no further oRdValid after reset release until a new iRdStart.

Verification
REQ-036 Write addr 3 data 16'hA5A5 -> cycle 1: oCsnRam=0, oWrnRam=0, oAddrRam=3, oWtDtRam=16'hA5A5, oWrAck=1, oWrErr=0.
REQ-037 Write addr 12 -> oWrAck=1, oWrErr=1, oCsnRam stays 1; SRAM model contents unchanged.
REQ-038 Write words 16'h0100+k to k=0..9, then iRdStart -> oRdValid cycles 3..12 with oRdIdx=0..9, oRdData=16'h0100..16'h0109; oDone=1 only in cycle 12; oBusy low from cycle 13.
REQ-039 iWrReq and iRdStart in same cycle -> write performed, no sweep; iRdStart pulsed during sweep -> ignored, exactly 10 oRdValid.
REQ-040 iRsn=0 in cycle 5 of a sweep -> all outputs at reset values immediately; after release no oRdValid/oDone until next iRdStart; next sweep returns full 0..9 correctly.

Source files
------------

// File: rtl/sram_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sram_access_ctrl
//  Purpose  : Single-port SRAM access controller. Performs host single-word
//             writes and full sweep-reads of addresses 0..DEPTH-1 against an
//             SRAM with registered read data (one cycle read latency).
//  Ports    : iClk12M / iRsn            clock, async active-low reset
//             iWrReq/iWrAddr/iWrData    host write request
//             iRdStart                  host sweep-read request
//             oBusy/oWrAck/oWrErr       status and write completion pulses
//             oRdValid/oRdData/oRdIdx   sweep read results
//             oDone                     sweep completion pulse
//             oCsnRam/oWrnRam/oAddrRam/oWtDtRam/iRdDtRam   SRAM side
//  Revision : 1.0  initial release
// ============================================================================
module sram_access_ctrl #(
    parameter int DEPTH = 10,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic          iClk12M,
    input  logic          iRsn,
    input  logic          iWrReq,
    input  logic [AW-1:0] iWrAddr,
    input  logic [DW-1:0] iWrData,
    input  logic          iRdStart,
    output logic          oBusy,
    output logic          oWrAck,
    output logic          oWrErr,
    output logic          oRdValid,
    output logic [DW-1:0] oRdData,
    output logic [AW-1:0] oRdIdx,
    output logic          oDone,
    output logic          oCsnRam,
    output logic          oWrnRam,
    output logic [AW-1:0] oAddrRam,
    output logic [DW-1:0] oWtDtRam,
    input  logic [DW-1:0] iRdDtRam
);

    localparam logic [AW-1:0] c_LAST      = AW'(DEPTH - 1);
    localparam logic [AW:0]   c_DEPTH_EXT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          csn_q, csn_d;
    logic          wrn_q, wrn_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdat_q, wdat_d;
    logic          busy_q, busy_d;
    logic          wrack_q, wrack_d;
    logic          wrerr_q, wrerr_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] ridx_q, ridx_d;
    logic          done_q, done_d;
    // A read access was issued last cycle, so iRdDtRam carries that word now.
    logic          cap_q, cap_d;
    logic [AW-1:0] cap_idx_q, cap_idx_d;

    logic          w_wr_in_range;

    assign w_wr_in_range = ({1'b0, iWrAddr} < c_DEPTH_EXT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        csn_d     = 1'b1;
        wrn_d     = 1'b1;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        wrack_d   = 1'b0;
        wrerr_d   = 1'b0;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        ridx_d    = ridx_q;
        done_d    = 1'b0;
        cap_d     = ~csn_q & wrn_q;
        cap_idx_d = addr_q;

        if (cap_q) begin
            rvalid_d = 1'b1;
            rdata_d  = iRdDtRam;
            ridx_d   = cap_idx_q;
            done_d   = (cap_idx_q == c_LAST);
        end

        unique case (state_q)
            S_IDLE: begin
                if (iWrReq) begin
                    state_d = S_WRITE;
                    addr_d  = iWrAddr;
                    wdat_d  = iWrData;
                    wrack_d = 1'b1;
                    // Out-of-range writes are acknowledged but never reach the SRAM.
                    wrerr_d = ~w_wr_in_range;
                    csn_d   = ~w_wr_in_range;
                    wrn_d   = ~w_wr_in_range;
                end else if (iRdStart) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                    addr_d  = '0;
                    csn_d   = 1'b0;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_READ: begin
                // Terminate on the last address rather than letting the counter wrap.
                if (cnt_q == c_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    addr_d = cnt_q + 1'b1;
                    csn_d  = 1'b0;
                end
            end
            S_DRAIN: begin
                // done_q marks the cycle presenting the final word.
                if (done_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            csn_q     <= 1'b1;
            wrn_q     <= 1'b1;
            addr_q    <= '0;
            wdat_q    <= '0;
            busy_q    <= 1'b0;
            wrack_q   <= 1'b0;
            wrerr_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            ridx_q    <= '0;
            done_q    <= 1'b0;
            cap_q     <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            csn_q     <= csn_d;
            wrn_q     <= wrn_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            busy_q    <= busy_d;
            wrack_q   <= wrack_d;
            wrerr_q   <= wrerr_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            ridx_q    <= ridx_d;
            done_q    <= done_d;
            cap_q     <= cap_d;
            cap_idx_q <= cap_idx_d;
        end
    end

    assign oBusy    = busy_q;
    assign oWrAck   = wrack_q;
    assign oWrErr   = wrerr_q;
    assign oRdValid = rvalid_q;
    assign oRdData  = rdata_q;
    assign oRdIdx   = ridx_q;
    assign oDone    = done_q;
    assign oCsnRam  = csn_q;
    assign oWrnRam  = wrn_q;
    assign oAddrRam = addr_q;
    assign oWtDtRam = wdat_q;

endmodule
`default_nettype wire
